// File: rtl/param_write_arbiter.sv
// Two-requester parameter write arbiter with round-robin grant, post-write holdoff and shadow copy.
// Optional duplicate-write suppression is enabled with the PARAM_WRITE_DEDUP_EN macro.
module param_write_arbiter #(
    parameter int VALUE_WIDTH    = 16,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_valid,
    input  logic [2:0]             a_addr,
    input  logic [VALUE_WIDTH-1:0] a_value,
    output logic                   a_ready,
    input  logic                   b_valid,
    input  logic [2:0]             b_addr,
    input  logic [VALUE_WIDTH-1:0] b_value,
    output logic                   b_ready,
    output logic                   wr_valid,
    output logic [2:0]             wr_addr,
    output logic [VALUE_WIDTH-1:0] wr_value,
    output logic                   wr_src,
    input  logic                   wr_ready,
    input  logic [2:0]             rd_addr,
    output logic [VALUE_WIDTH-1:0] rd_value,
    output logic [7:0]             drop_count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // The counter is loaded with one less than the holdoff so HOLD lasts exactly HOLDOFF_CYCLES.
    localparam logic [7:0] HOLD_LOAD = (HOLDOFF_CYCLES == 0) ? 8'd0 : 8'(HOLDOFF_CYCLES - 1);

    state_t                 state_r;
    state_t                 state_s;
    logic                   ptr_b_r;
    logic [7:0]             hold_cnt_r;
    logic [VALUE_WIDTH-1:0] shadow_r [8];
    logic                   grant_a_s;
    logic                   grant_b_s;
    logic                   grant_s;
    logic                   dup_s;
    logic                   handshake_s;
    logic [2:0]             sel_addr_s;
    logic [VALUE_WIDTH-1:0] sel_value_s;

    // Grant selection: only in IDLE, pointer breaks ties.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (state_r == IDLE) begin
            if (a_valid && (!b_valid || !ptr_b_r)) begin
                grant_a_s = 1'b1;
            end else if (b_valid) begin
                grant_b_s = 1'b1;
            end else begin
                grant_a_s = 1'b0;
            end
        end else begin
            grant_b_s = 1'b0;
        end
    end

    assign grant_s     = grant_a_s | grant_b_s;
    assign sel_addr_s  = grant_b_s ? b_addr : a_addr;
    assign sel_value_s = grant_b_s ? b_value : a_value;
    assign handshake_s = (state_r == ISSUE) && wr_ready;
    assign a_ready     = rst_n & grant_a_s;
    assign b_ready     = rst_n & grant_b_s;
    assign rd_value    = shadow_r[rd_addr];

`ifdef PARAM_WRITE_DEDUP_EN
    logic [7:0] shadow_valid_r;
    logic [7:0] drop_count_r;

    assign dup_s      = grant_s && shadow_valid_r[sel_addr_s] && (shadow_r[sel_addr_s] == sel_value_s);
    assign drop_count = drop_count_r;

    // Shadow-valid tracking and saturating count of suppressed duplicates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_valid_r <= 8'd0;
            drop_count_r   <= 8'd0;
        end else begin
            if (handshake_s) begin
                shadow_valid_r[wr_addr] <= 1'b1;
            end
            if (dup_s && (drop_count_r != 8'hFF)) begin
                drop_count_r <= drop_count_r + 8'd1;
            end
        end
    end
`else
    assign dup_s      = 1'b0;
    assign drop_count = 8'd0;
`endif

    // Next-state logic; a suppressed duplicate leaves the FSM in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s && !dup_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (wr_ready) begin
                    state_s = (HOLDOFF_CYCLES == 0) ? IDLE : HOLD;
                end else begin
                    state_s = ISSUE;
                end
            end
            HOLD: begin
                if (hold_cnt_r == 8'd0) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Write channel, pointer, holdoff counter and shadow bank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_valid   <= 1'b0;
            wr_addr    <= 3'd0;
            wr_value   <= '0;
            wr_src     <= 1'b0;
            ptr_b_r    <= 1'b0;
            hold_cnt_r <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                shadow_r[i] <= '0;
            end
        end else begin
            if (grant_s) begin
                ptr_b_r <= grant_a_s;
            end
            if (grant_s && !dup_s) begin
                wr_valid <= 1'b1;
                wr_addr  <= sel_addr_s;
                wr_value <= sel_value_s;
                wr_src   <= grant_b_s;
            end else if (handshake_s) begin
                wr_valid <= 1'b0;
            end
            if (handshake_s) begin
                shadow_r[wr_addr] <= wr_value;
                hold_cnt_r        <= HOLD_LOAD;
            end else if ((state_r == HOLD) && (hold_cnt_r != 8'd0)) begin
                hold_cnt_r <= hold_cnt_r - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_param_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_param_write_arbiter;
    localparam int HOLDOFF = 4;

    logic        clk;
    logic        rst_n, a_valid, b_valid, wr_ready;
    logic [2:0]  a_addr, b_addr, rd_addr;
    logic [15:0] a_value, b_value;
    logic        a_ready, b_ready, wr_valid, wr_src;
    logic [2:0]  wr_addr;
    logic [15:0] wr_value, rd_value;
    logic [7:0]  drop_count;

    logic        c_rst_n, c_a_ready, c_b_ready, c_wr_valid, c_wr_src;
    logic [15:0] c_a_value, c_b_value, c_wr_value, c_rd_value;
    logic [2:0]  c_wr_addr;
    logic [7:0]  c_drop_count;

    param_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_value(a_value), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_value(b_value), .b_ready(b_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_value(wr_value), .wr_src(wr_src),
        .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_value(rd_value), .drop_count(drop_count)
    );

    param_write_arbiter #(.VALUE_WIDTH(16), .HOLDOFF_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(c_rst_n),
        .a_valid(1'b1), .a_addr(3'd1), .a_value(c_a_value), .a_ready(c_a_ready),
        .b_valid(1'b1), .b_addr(3'd2), .b_value(c_b_value), .b_ready(c_b_ready),
        .wr_valid(c_wr_valid), .wr_addr(c_wr_addr), .wr_value(c_wr_value), .wr_src(c_wr_src),
        .wr_ready(1'b1), .rd_addr(3'd0), .rd_value(c_rd_value), .drop_count(c_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_count = 0;
    int total_count = 0;
    int cyc = 0;

    // Reference model: pending write, remaining holdoff, favoured requester, shadow contents.
    bit          m_busy = 1'b0;
    int          m_hold = 0;
    bit          m_fav_b = 1'b0;
    logic [15:0] m_shadow [8];
    bit          m_sv [8];
    logic [2:0]  m_addr = 3'd0;
    logic [15:0] m_value = 16'd0;
    bit          m_src = 1'b0;
    int          m_drop = 0;
    bit          a_taken = 1'b0, b_taken = 1'b0, obs_a = 1'b0, obs_b = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_count++;
        assert (obs === exp) begin
            pass_count++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_hold = 0; m_fav_b = 1'b0; m_drop = 0;
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = 16'd0;
            m_sv[i] = 1'b0;
        end
    endtask

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic cycle();
        bit ga, gb, dup;
        logic [2:0]  ad;
        logic [15:0] va;
        #1;
        ga = 1'b0; gb = 1'b0; dup = 1'b0;
        if (rst_n && !m_busy && m_hold == 0) begin
            if (a_valid && (!b_valid || !m_fav_b)) ga = 1'b1;
            else if (b_valid) gb = 1'b1;
        end
        obs_a = a_ready; obs_b = b_ready;
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        chk("wr_valid", wr_valid, m_busy);
        if (m_busy) begin
            chk("wr_addr", wr_addr, m_addr);
            chk("wr_value", wr_value, m_value);
            chk("wr_src", wr_src, m_src);
        end
        chk("rd_value", rd_value, m_shadow[rd_addr]);
        chk("drop_count", drop_count, m_drop);
        @(posedge clk);
        cyc++;
        a_taken = 1'b0; b_taken = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_busy && wr_ready) begin
                m_shadow[m_addr] = m_value;
                m_sv[m_addr] = 1'b1;
                m_busy = 1'b0;
                m_hold = HOLDOFF;
            end else if (m_hold > 0) begin
                m_hold--;
            end
            if (ga || gb) begin
                ad = ga ? a_addr : b_addr;
                va = ga ? a_value : b_value;
`ifdef PARAM_WRITE_DEDUP_EN
                dup = m_sv[ad] && (m_shadow[ad] == va);
`endif
                m_fav_b = ga;
                a_taken = ga; b_taken = gb;
                if (dup) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_busy = 1'b1; m_addr = ad; m_value = va; m_src = gb;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_a(output int n);
        n = -1;
        for (int i = 0; i < 40 && n < 0; i++) begin
            cycle();
            if (obs_a) n = cyc;
        end
        if (n < 0) chk("timeout_a", 32'd0, 32'd1);
    endtask

    function automatic logic [15:0] pick_value();
        case ($urandom_range(0, 3))
            0: return 16'h1200;
            1: return 16'h4000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic drive_random();
        if (a_taken || !a_valid) begin
            a_valid = ($urandom_range(0, 2) != 0);
            a_addr  = 3'($urandom_range(0, 7));
            a_value = pick_value();
        end
        if (b_taken || !b_valid) begin
            b_valid = ($urandom_range(0, 2) != 0);
            b_addr  = 3'($urandom_range(0, 7));
            b_value = pick_value();
        end
        wr_ready = ($urandom_range(0, 3) != 0);
        rd_addr  = 3'($urandom_range(0, 7));
    endtask

    initial begin
        int t0, t1, exp_src, nwr, exp_drop, exp_wr;
        rst_n = 1'b0; c_rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; wr_ready = 1'b1;
        a_addr = 3'd0; b_addr = 3'd0; a_value = 16'd0; b_value = 16'd0; rd_addr = 3'd0;
        c_a_value = 16'd0; c_b_value = 16'd100;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Zero-holdoff instance: one write every two cycles, sources alternating.
        c_rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            c_a_value = 16'(k); c_b_value = 16'(k + 100);
            #1;
            chk("h0_wr_valid", c_wr_valid, (k % 2 == 1));
            if (k % 2 == 1) chk("h0_wr_src", c_wr_src, (k / 2) % 2);
            @(negedge clk);
        end

        // Reset values, readies low with requests pending in reset.
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        cycle();
        do_reset();
        #1;
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_wr_addr", wr_addr, 3'd0);
        chk("rst_wr_value", wr_value, 16'd0);
        chk("rst_wr_src", wr_src, 1'b0);
        chk("rst_drop", drop_count, 8'd0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            chk("rst_shadow", rd_value, 16'd0);
        end

        // Single write then back-to-back request: grant gap covers ISSUE plus holdoff.
        a_valid = 1'b1; a_addr = 3'd3; a_value = 16'h4000; wr_ready = 1'b1;
        wait_a(t0);
        a_addr = 3'd4; a_value = 16'h0001;
        wait_a(t1);
        chk("holdoff_gap", t1 - t0, 6);
        a_valid = 1'b0; rd_addr = 3'd3;
        #1;
        chk("rd_addr3", rd_value, 16'h4000);

        // Both requesters continuously valid: alternating grants from A.
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; exp_src = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (obs_a || obs_b) begin
                chk("alt_src", obs_b, exp_src);
                exp_src = 1 - exp_src;
            end
            if (a_taken) a_value = 16'($urandom);
            if (b_taken) b_value = 16'($urandom);
        end

        // Stalled write: outputs stable for ten cycles, single shadow update.
        do_reset();
        a_valid = 1'b1; a_addr = 3'd1; a_value = 16'hABCD; wr_ready = 1'b0;
        wait_a(t0);
        a_valid = 1'b0; rd_addr = 3'd1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stall_valid", wr_valid, 1'b1);
            chk("stall_value", wr_value, 16'hABCD);
            chk("stall_old_rd", rd_value, 16'd0);
            cycle();
        end
        wr_ready = 1'b1;
        cycle();
        #1;
        chk("stall_rd", rd_value, 16'hABCD);

        // Duplicate write to addr 5.
        do_reset();
        a_valid = 1'b1; a_addr = 3'd5; a_value = 16'h1200;
        wait_a(t0);
        a_valid = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        a_valid = 1'b1;
        wait_a(t1);
        a_valid = 1'b0; nwr = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (wr_valid) nwr++;
            cycle();
        end
`ifdef PARAM_WRITE_DEDUP_EN
        exp_drop = 1; exp_wr = 0;
`else
        exp_drop = 0; exp_wr = 1;
`endif
        chk("dup_drop", drop_count, exp_drop);
        chk("dup_writes", nwr, exp_wr);

        // Reset while a write to addr 2 is pending.
        do_reset();
        a_valid = 1'b1; a_addr = 3'd2; a_value = 16'h7F00; wr_ready = 1'b0;
        wait_a(t0);
        a_valid = 1'b0;
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1; wr_ready = 1'b1; rd_addr = 3'd2;
        #1;
        chk("rst_abandon_valid", wr_valid, 1'b0);
        chk("rst_abandon_shadow", rd_value, 16'd0);
        a_valid = 1'b1; b_valid = 1'b1; b_addr = 3'd6; b_value = 16'h0055;
        cycle();
        chk("rst_ptr_a", obs_a, 1'b1);
        a_valid = 1'b0;

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            drive_random();
            cycle();
        end

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule
